// File: rtl/parking_pkg.sv
// Shared types and constants for the parking slot scheduler.
package parking_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE   = 2'd1,
        RESP    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam logic DIR_ENTRY = 1'b1;
    localparam logic DIR_EXIT  = 1'b0;

endpackage

// File: rtl/parking_slot_scheduler_if.sv
// Gate-side bus: per-gate request/direction/slot in, grant and result fields out.
interface parking_slot_scheduler_if #(
    parameter int N_GATES = 4,
    parameter int N_SLOTS = 8,
    parameter int TIME_W  = 8
);
    localparam int SLOT_W = $clog2(N_SLOTS);

    // Gate g holds request[g] (with is_entry/exit_slot stable) until it has
    // seen grant[g] followed by a one-cycle done; grant[g] then stays high
    // until request[g] is dropped, which frees the scheduler for the next gate.
    logic [N_GATES-1:0]        request;
    logic [N_GATES-1:0]        is_entry;
    logic [N_GATES*SLOT_W-1:0] exit_slot;
    logic [N_GATES-1:0]        grant;
    logic                      done;
    logic [SLOT_W-1:0]         slot_out;
    logic [TIME_W-1:0]         duration;
    logic                      error;

    modport master (
        output request, is_entry, exit_slot,
        input  grant, done, slot_out, duration, error
    );

    modport slave (
        input  request, is_entry, exit_slot,
        output grant, done, slot_out, duration, error
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requesting index at or after rr_ptr.
module rr_arbiter #(
    parameter int N = 4,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     request,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [N-1:0]     winner_onehot,
    output logic [IDX_W-1:0] winner_idx
);

    always_comb begin
        logic found;
        int   idx;
        found         = 1'b0;
        idx           = 0;
        winner_onehot = '0;
        winner_idx    = '0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(rr_ptr) + i) % N;
            if (!found && request[idx]) begin
                found              = 1'b1;
                winner_onehot[idx] = 1'b1;
                winner_idx         = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/parking_slot_scheduler.sv
// Arbitrates gate transactions onto one shared slot table: entry allocates the
// lowest free slot and stamps TimeData, exit frees a slot and reports the stay.
module parking_slot_scheduler
    import parking_pkg::*;
#(
    parameter int N_GATES = 4,
    parameter int N_SLOTS = 8,
    parameter int TIME_W  = 8,
    localparam int SLOT_W = $clog2(N_SLOTS),
    localparam int CNT_W  = $clog2(N_SLOTS + 1),
    localparam int GATE_W = (N_GATES > 1) ? $clog2(N_GATES) : 1
) (
    input  logic                     clock,
    input  logic                     reset,
    parking_slot_scheduler_if.slave  bus,
    input  logic [TIME_W-1:0]        TimeData,
    output logic                     full,
    output logic [CNT_W-1:0]         free_count,
    output state_t                   state_dbg,
    output logic [GATE_W-1:0]        rr_ptr_dbg
);

    state_t              state_q, state_d;
    logic [GATE_W-1:0]   gate_q, gate_d;
    logic [GATE_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [N_GATES-1:0]  grant_q, grant_d;
    logic                done_q, done_d;
    logic [SLOT_W-1:0]   slot_out_q, slot_out_d;
    logic [TIME_W-1:0]   duration_q, duration_d;
    logic                error_q, error_d;
    logic                dir_q, dir_d;
    logic [SLOT_W-1:0]   xslot_q, xslot_d;
    logic [N_SLOTS-1:0]  occ_q, occ_d;
    logic [TIME_W-1:0]   entry_time_q [N_SLOTS];
    logic [TIME_W-1:0]   entry_time_d [N_SLOTS];
    logic [CNT_W-1:0]    free_count_q, free_count_d;
    logic                full_q, full_d;

    logic [N_GATES-1:0]  req;
    logic [N_GATES-1:0]  win_oh;
    logic [GATE_W-1:0]   win_idx;
    logic                free_found;
    logic [SLOT_W-1:0]   free_idx;

    assign req = bus.request;

    rr_arbiter #(.N(N_GATES)) u_arb (
        .request       (req),
        .rr_ptr        (rr_ptr_q),
        .winner_onehot (win_oh),
        .winner_idx    (win_idx)
    );

    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = N_SLOTS - 1; i >= 0; i--) begin
            if (!occ_q[i]) begin
                free_found = 1'b1;
                free_idx   = SLOT_W'(i);
            end
        end
    end

    always_comb begin
        logic [CNT_W-1:0] cnt;
        state_d      = state_q;
        gate_d       = gate_q;
        rr_ptr_d     = rr_ptr_q;
        grant_d      = grant_q;
        done_d       = 1'b0;
        slot_out_d   = slot_out_q;
        duration_d   = duration_q;
        error_d      = error_q;
        dir_d        = dir_q;
        xslot_d      = xslot_q;
        occ_d        = occ_q;
        entry_time_d = entry_time_q;

        case (state_q)
            IDLE: begin
                if (|req) begin
                    gate_d   = win_idx;
                    grant_d  = win_oh;
                    rr_ptr_d = GATE_W'((int'(win_idx) + 1) % N_GATES);
                    dir_d    = bus.is_entry[win_idx];
                    xslot_d  = bus.exit_slot[win_idx*SLOT_W +: SLOT_W];
                    state_d  = SERVE;
                end
            end
            SERVE: begin
                done_d  = 1'b1;
                state_d = RESP;
                if (dir_q == DIR_ENTRY) begin
                    duration_d = '0;
                    if (free_found) begin
                        occ_d[free_idx]        = 1'b1;
                        entry_time_d[free_idx] = TimeData;
                        slot_out_d             = free_idx;
                        error_d                = 1'b0;
                    end else begin
                        slot_out_d = '0;
                        error_d    = 1'b1;
                    end
                end else begin
                    slot_out_d = xslot_q;
                    // Modular subtraction handles a time counter that wrapped while parked.
                    if (int'(xslot_q) < N_SLOTS && occ_q[xslot_q]) begin
                        duration_d     = TimeData - entry_time_q[xslot_q];
                        occ_d[xslot_q] = 1'b0;
                        error_d        = 1'b0;
                    end else begin
                        duration_d = '0;
                        error_d    = 1'b1;
                    end
                end
            end
            RESP: begin
                state_d = RELEASE;
            end
            RELEASE: begin
                if (!req[gate_q]) begin
                    grant_d = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        cnt = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            if (!occ_d[i]) cnt = cnt + CNT_W'(1);
        end
        free_count_d = cnt;
        full_d       = (cnt == '0);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            gate_q       <= '0;
            rr_ptr_q     <= '0;
            grant_q      <= '0;
            done_q       <= 1'b0;
            slot_out_q   <= '0;
            duration_q   <= '0;
            error_q      <= 1'b0;
            dir_q        <= 1'b0;
            xslot_q      <= '0;
            occ_q        <= '0;
            free_count_q <= CNT_W'(N_SLOTS);
            full_q       <= 1'b0;
            for (int i = 0; i < N_SLOTS; i++) entry_time_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            gate_q       <= gate_d;
            rr_ptr_q     <= rr_ptr_d;
            grant_q      <= grant_d;
            done_q       <= done_d;
            slot_out_q   <= slot_out_d;
            duration_q   <= duration_d;
            error_q      <= error_d;
            dir_q        <= dir_d;
            xslot_q      <= xslot_d;
            occ_q        <= occ_d;
            free_count_q <= free_count_d;
            full_q       <= full_d;
            for (int i = 0; i < N_SLOTS; i++) entry_time_q[i] <= entry_time_d[i];
        end
    end

    assign bus.grant    = grant_q;
    assign bus.done     = done_q;
    assign bus.slot_out = slot_out_q;
    assign bus.duration = duration_q;
    assign bus.error    = error_q;
    assign full         = full_q;
    assign free_count   = free_count_q;
    assign state_dbg    = state_q;
    assign rr_ptr_dbg   = rr_ptr_q;

endmodule
